shift_add_mult8: RTL and testbench

SHIFT_ADD_MULT8 -- requirements
Module: shift_add_mult8

---
 rtl/shift_add_mult8_pkg.sv | 23 ++
 rtl/shift_add_mult8_if.sv | 29 ++
 rtl/shift_add_mult8_adder.sv | 31 +++
 rtl/shift_add_mult8.sv | 105 ++++++++++
 tb/tb_shift_add_mult8.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/shift_add_mult8_pkg.sv
//------------------------------------------------------------------------------
// Module   : shift_add_mult8_pkg
// Function : Shared FSM state type and sizing constants for the 8x8 multiplier.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package shift_add_mult8_pkg;

   localparam int MULT_W     = 8;
   localparam int PROD_W     = 16;
   localparam int MULT_ITERS = 8;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_add_mult8_if.sv
//------------------------------------------------------------------------------
// Module   : shift_add_mult8_if
// Function : Start/operand request and busy/done/product response bundle.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface shift_add_mult8_if;
   import shift_add_mult8_pkg::*;

   logic              start;
   logic [MULT_W-1:0] a;
   logic [MULT_W-1:0] b;
   logic              busy;
   logic              done;
   logic [PROD_W-1:0] product;

   modport master (
      output start, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, a, b,
      output busy, done, product
   );
endinterface

`default_nettype wire

// File: rtl/shift_add_mult8_adder.sv
//------------------------------------------------------------------------------
// Module   : rippleCarry8bitAdder
// Function : 8-bit ripple-carry adder built from a chain of full adders.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rippleCarry8bitAdder (
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   input  logic       i_c0,
   output logic [7:0] o_s,
   output logic       o_c8
);

   logic [8:0] w_c;

   assign w_c[0] = i_c0;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_bit
         assign o_s[gi]    = i_a[gi] ^ i_b[gi] ^ w_c[gi];
         assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
      end
   endgenerate

   assign o_c8 = w_c[8];

endmodule

`default_nettype wire

// File: rtl/shift_add_mult8.sv
//------------------------------------------------------------------------------
// Module   : shift_add_mult8
// Function : Sequential 8x8 unsigned shift-and-add multiplier (8 iterations).
//            Optional MULT_ZERO_BYPASS_EN: zero operand skips straight to DONE.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shift_add_mult8
   import shift_add_mult8_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   shift_add_mult8_if.slave    bus
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [MULT_W-1:0]   r_mcand;
   logic [MULT_W-1:0]   r_mplier;
   // Bit 0 of the accumulator is always shifted out before it is read, so it is not stored.
   logic [PROD_W-1:1]   r_acc;
   logic [CNT_W-1:0]    r_count;
   logic [PROD_W-1:0]   r_product;
   logic [MULT_W-1:0]   w_addend;
   logic [MULT_W-1:0]   w_sum;
   logic                w_carry;
   logic [PROD_W-1:0]   w_acc_nxt;
   logic                w_last;
   logic                w_zero_op;

   assign w_addend = r_mplier[0] ? r_mcand : '0;

   rippleCarry8bitAdder u_adder (
      .i_a  (r_acc[PROD_W-1:MULT_W]),
      .i_b  (w_addend),
      .i_c0 (1'b0),
      .o_s  (w_sum),
      .o_c8 (w_carry)
   );

   assign w_acc_nxt = {w_carry, w_sum, r_acc[MULT_W-1:1]};
   assign w_last    = (r_count == CNT_W'(MULT_ITERS - 1));

`ifdef MULT_ZERO_BYPASS_EN
   assign w_zero_op = (bus.a == '0) || (bus.b == '0);
`else
   assign w_zero_op = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = w_zero_op ? S_DONE : S_RUN;
         S_RUN:   if (w_last)    w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_count   <= '0;
         r_product <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_mcand  <= bus.a;
                  r_mplier <= bus.b;
                  r_acc    <= '0;
                  r_count  <= '0;
                  if (w_zero_op) r_product <= '0;
               end
            end
            S_RUN: begin
               r_acc    <= w_acc_nxt[PROD_W-1:1];
               r_mplier <= r_mplier >> 1;
               r_count  <= r_count + 1'b1;
               if (w_last) r_product <= w_acc_nxt;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy    = (r_state != S_IDLE);
   assign bus.done    = (r_state == S_DONE);
   assign bus.product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_mult8.sv
//------------------------------------------------------------------------------
// Module   : tb_shift_add_mult8
// Function : Self-checking bench for shift_add_mult8 (honours MULT_ZERO_BYPASS_EN).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_add_mult8;

   logic clk = 1'b0;
   logic rst;

   shift_add_mult8_if bus ();

   shift_add_mult8 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

`ifdef MULT_ZERO_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;
   int          done_k_q[$];
   logic [15:0] done_p_q[$];
   int          busy_cnt;

   // Cycles from the accepting edge to the done cycle, straight from the timing rules.
   function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
      return (BYPASS && (a == 8'd0 || b == 8'd0)) ? 0 : 8;
   endfunction

   // k counts cycles after the accepting edge; start stays high while k < hold_k or k == alt_k.
   task automatic run_op(input logic [7:0] a0, input logic [7:0] b0,
                         input int hold_k, input int alt_k,
                         input logic [7:0] a1, input logic [7:0] b1, input int ncyc);
      done_k_q.delete();
      done_p_q.delete();
      busy_cnt = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = a0;
      bus.b     = b0;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.done === 1'b1) begin
            done_k_q.push_back(k);
            done_p_q.push_back(bus.product);
         end
         bus.start = (k < hold_k) || (k == alt_k);
         if (k == alt_k) begin
            bus.a = a1;
            bus.b = b1;
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = 8'd0;
      bus.b     = 8'd0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      n_tests++;
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      n_tests++;
      if (bus.product !== 16'h0000) begin n_fail++; $display("FAIL reset_product got=%h exp=0000", bus.product); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed(input string nm, input logic [7:0] a, input logic [7:0] b);
      int          got_k;
      logic [15:0] got_p;
      run_op(a, b, 0, -1, 8'd0, 8'd0, 14);
      got_k = (done_k_q.size() > 0) ? done_k_q[0] : -1;
      got_p = (done_p_q.size() > 0) ? done_p_q[0] : 16'hxxxx;
      n_tests++;
      if (done_k_q.size() != 1) begin n_fail++; $display("FAIL %s_done_count got=%0d exp=1", nm, done_k_q.size()); end
      n_tests++;
      if (got_k != exp_lat(a, b)) begin n_fail++; $display("FAIL %s_done_cycle got=%0d exp=%0d", nm, got_k, exp_lat(a, b)); end
      n_tests++;
      if (got_p !== 16'(a) * 16'(b)) begin n_fail++; $display("FAIL %s_product got=%h exp=%h", nm, got_p, 16'(a) * 16'(b)); end
      n_tests++;
      if (busy_cnt != exp_lat(a, b) + 1) begin n_fail++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", nm, busy_cnt, exp_lat(a, b) + 1); end
   endtask

   task automatic test_ignore_start();
      run_op(8'd3, 8'd5, 0, 2, 8'd200, 8'd200, 16);
      n_tests++;
      if (done_k_q.size() != 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d exp=1", done_k_q.size()); end
      n_tests++;
      if (done_p_q.size() < 1 || done_p_q[0] !== 16'h000F) begin
         n_fail++; $display("FAIL ignore_product got=%h exp=000f", (done_p_q.size() > 0) ? done_p_q[0] : 16'hxxxx);
      end
      n_tests++;
      if (bus.product !== 16'h000F) begin n_fail++; $display("FAIL ignore_product_held got=%h exp=000f", bus.product); end
   endtask

   task automatic test_abort();
      int n_done = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'd100;
      bus.b     = 8'd100;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_async_busy got=%b exp=0", bus.busy); end
      n_tests++;
      if (bus.product !== 16'h0000) begin n_fail++; $display("FAIL abort_async_product got=%h exp=0000", bus.product); end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) n_done++;
      end
      n_tests++;
      if (n_done != 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
      n_tests++;
      if (bus.product !== 16'h0000) begin n_fail++; $display("FAIL abort_product got=%h exp=0000", bus.product); end
      test_directed("after_abort", 8'd7, 8'd6);
   endtask

   task automatic test_back_to_back();
      run_op(8'd2, 8'd3, 10, 8, 8'd4, 8'd5, 24);
      n_tests++;
      if (done_k_q.size() != 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", done_k_q.size()); end
      if (done_k_q.size() == 2) begin
         n_tests++;
         if (done_k_q[0] != 8) begin n_fail++; $display("FAIL b2b_first_cycle got=%0d exp=8", done_k_q[0]); end
         n_tests++;
         if (done_k_q[1] - done_k_q[0] != 10) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=10", done_k_q[1] - done_k_q[0]); end
         n_tests++;
         if (done_p_q[0] !== 16'h0006) begin n_fail++; $display("FAIL b2b_product0 got=%h exp=0006", done_p_q[0]); end
         n_tests++;
         if (done_p_q[1] !== 16'h0014) begin n_fail++; $display("FAIL b2b_product1 got=%h exp=0014", done_p_q[1]); end
      end
      n_tests++;
      if (busy_cnt != 18) begin n_fail++; $display("FAIL b2b_busy_cycles got=%0d exp=18", busy_cnt); end
   endtask

   task automatic test_random();
      logic [7:0] a;
      logic [7:0] b;
      for (int i = 0; i < 24; i++) begin
         a = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
         b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
         test_directed($sformatf("rand%0d", i), a, b);
      end
   endtask

   initial begin
      test_reset();
      test_directed("mult_13x11", 8'd13, 8'd11);
      test_directed("mult_255x255", 8'd255, 8'd255);
      test_directed("zero_a", 8'd0, 8'd77);
      test_directed("zero_b", 8'd77, 8'd0);
      test_ignore_start();
      test_abort();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
